pc_arbiter: RTL
===============

# pc_arbiter

Two-input packet arbiter that merges two upstream packet streams into one valid/ready output stream. It drives the RECEIVE_PC port of the packet `queue`, acting as the transmitter for that receiver. Each winning packet is captured into a one-entry output register, and inputs are granted either round-robin or by fixed priority.

## Interface
- PACKET_WIDTH — shared codebase packet width (from the common param include) — width of every data port
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- RECEIVE_A_PC_VALID  input  1  input A has a packet
- RECEIVE_A_PC_DATA  input  PACKET_WIDTH  input A packet
- RECEIVE_A_PC_READY  output  1  input A packet accepted this cycle when VALID also high
- RECEIVE_B_PC_VALID / RECEIVE_B_PC_DATA / RECEIVE_B_PC_READY — same as A, for input B
- SEND_PC_VALID  output  1  output register holds a packet
- SEND_PC_DATA  output  PACKET_WIDTH  output packet; stable while VALID && !READY
- SEND_PC_READY  input  1  downstream (queue) accepts

## Operation
- Transfer on any port occurs in a cycle where VALID && READY at the rising edge.
- Output slot register: `full` flag plus data. `accept = !RST && (!full || SEND_PC_READY)`.
- Grant, combinational from the current VALIDs and priority state:
  - only A valid → A; only B valid → B;
  - both valid → preferred input (`prio`: 0 = A, 1 = B).
- RECEIVE_x_PC_READY = accept && grant_x; at most one READY is high per cycle. READY never depends on its own VALID except through grant.
- On an input transfer the slot loads that DATA and sets full. On an output transfer with no input transfer, full clears. When both happen in the same cycle, the slot reloads and stays full.
- `prio` updates only on an input transfer: it is set to the non-granted input.
- Ungranted input: READY low. It must hold VALID/DATA and is served at the latest on the next accept cycle (round-robin).
- SEND_PC_DATA is undefined while SEND_PC_VALID = 0, and the bench must not check it then.

## Timing
- Reset values (RST high at a rising edge): SEND_PC_VALID = 0, full = 0, prio = 0 (A). RECEIVE_A_PC_READY and RECEIVE_B_PC_READY are 0 for every cycle RST is high.
- Latency: 1 cycle. A packet accepted at edge n appears on SEND_PC with VALID = 1 after edge n.
- Throughput: 1 packet/cycle while SEND_PC_READY is held high.
- Full and SEND_PC_READY = 0: both input READYs are 0, and the slot and prio are unchanged.
- Reset mid-operation: the held packet is dropped, and none of the pending inputs is accepted during reset. The first accept is possible in the first cycle after RST falls.
- SEND_PC_READY→RECEIVE_x_PC_READY is a combinational path, which is permitted. There is no path from VALID in to VALID out within a cycle.

## Configuration
- PC_ARBITER_ROUND_ROBIN_EN:
  - defined: `prio` alternates as described in Operation.
  - undefined: `prio` is fixed at 0, so A always wins simultaneous requests and the `prio` register is removed. B can starve, which is allowed.

## Structure
- PACKET_WIDTH and the VALID/READY handshake convention belong in the shared param include. No new package types are needed.
- One sub-module: `pc_slot`, a one-entry valid/ready register stage with load/unload/simultaneous handling. `pc_arbiter` holds the grant logic, `prio`, and one `pc_slot` instance.

## Test plan
- Reset: RST = 1 with both inputs valid → all READYs 0 and SEND_PC_VALID = 0. After release with downstream ready → A is transferred first, SEND_PC_DATA = A data one cycle later.
- Single stream: B only, 16 packets 0x1..0x10, SEND_PC_READY = 1 → output is 0x1..0x10 in order, one per cycle after 1-cycle latency.
- Contention, round-robin macro defined: A and B continuously valid, ready held high → output alternates A,B,A,B… starting with A, with no packet lost or duplicated.
- Contention, macro undefined: same stimulus → every output packet comes from A and RECEIVE_B_PC_READY stays 0.
- Backpressure: slot full, SEND_PC_READY = 0 for 5 cycles → SEND_PC_DATA stable and input READYs 0. When ready is raised, the held packet and then the next packet leave on consecutive cycles.
- End to end: pc_arbiter feeding `queue` with 500 random packets per input and a random downstream ready → the queue output matches the per-input order of each stream, with all 1000 packets delivered.

Source files
------------

// File: rtl/pc_arbiter_pkg.sv
// Shared packet parameters for the pc_* codebase slice.
// Valid/ready convention: a transfer happens on a rising edge where VALID && READY.
package pc_arbiter_pkg;

    localparam int PACKET_WIDTH = 32;

endpackage

// File: rtl/pc_slot.sv
// One-entry valid/ready register stage: holds a single packet between load and unload.
// accept is high when the slot can take a packet this cycle (empty, or draining this cycle).
module pc_slot
    import pc_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [PACKET_WIDTH-1:0] load_data,
    input  logic                    unload_ready,
    output logic                    full,
    output logic [PACKET_WIDTH-1:0] data,
    output logic                    accept
);

    assign accept = !rst && (!full || unload_ready);

    // A load takes precedence over an unload in the same cycle, so the slot stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload_ready) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/pc_arbiter.sv
// Two-input packet arbiter merging streams A and B into one registered valid/ready output.
// Define PC_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise A has fixed priority.
module pc_arbiter
    import pc_arbiter_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RECEIVE_A_PC_VALID,
    input  logic [PACKET_WIDTH-1:0] RECEIVE_A_PC_DATA,
    output logic                    RECEIVE_A_PC_READY,
    input  logic                    RECEIVE_B_PC_VALID,
    input  logic [PACKET_WIDTH-1:0] RECEIVE_B_PC_DATA,
    output logic                    RECEIVE_B_PC_READY,
    output logic                    SEND_PC_VALID,
    output logic [PACKET_WIDTH-1:0] SEND_PC_DATA,
    input  logic                    SEND_PC_READY
);

    logic                    prio;
    logic                    grant_a;
    logic                    grant_b;
    logic                    accept;
    logic                    xfer_a;
    logic                    xfer_b;
    logic                    load;
    logic [PACKET_WIDTH-1:0] load_data;

    assign grant_a = RECEIVE_A_PC_VALID && (!RECEIVE_B_PC_VALID || !prio);
    assign grant_b = RECEIVE_B_PC_VALID && !grant_a;

    assign RECEIVE_A_PC_READY = accept && grant_a;
    assign RECEIVE_B_PC_READY = accept && grant_b;

    assign xfer_a    = RECEIVE_A_PC_READY && RECEIVE_A_PC_VALID;
    assign xfer_b    = RECEIVE_B_PC_READY && RECEIVE_B_PC_VALID;
    assign load      = xfer_a || xfer_b;
    assign load_data = xfer_a ? RECEIVE_A_PC_DATA : RECEIVE_B_PC_DATA;

`ifdef PC_ARBITER_ROUND_ROBIN_EN
    // After a transfer, the input that was not served is preferred next time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prio <= 1'b0;
        end else if (load) begin
            prio <= xfer_a;
        end
    end
`else
    assign prio = 1'b0;
`endif

    pc_slot u_slot (
        .clk          (CLK),
        .rst          (RST),
        .load         (load),
        .load_data    (load_data),
        .unload_ready (SEND_PC_READY),
        .full         (SEND_PC_VALID),
        .data         (SEND_PC_DATA),
        .accept       (accept)
    );

endmodule
